// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and defaults for the sync FIFO, its read adapter and bench
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_SKID_DEPTH = 2;

  typedef logic [DEF_DATA_WIDTH-1:0] fifo_data_t;

  typedef enum logic [1:0] {
    OCC_IDLE,
    OCC_FILL,
    OCC_FULL
  } occ_state_e;

  // Classify a buffer level (stored beats plus the beat still in flight).
  function automatic occ_state_e occ_state_of(input int unsigned level, input int unsigned depth);
    if (level == 0) return OCC_IDLE;
    if (level >= depth) return OCC_FULL;
    return OCC_FILL;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// rtl/fifo_rd_stream_adapter_if.sv - FIFO read side and valid/ready stream side of the read adapter
interface fifo_rd_stream_adapter_if #(
  parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH
);

  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    output fifo_rd_en, m_valid, m_data,
    input  fifo_data_out, fifo_empty, fifo_underflow, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_valid, m_data,
    output fifo_data_out, fifo_empty, fifo_underflow, m_ready
  );

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// rtl/fifo_rd_skid_buf.sv - circular skid buffer: storage, wrapping pointers and occupancy
module fifo_rd_skid_buf #(
  parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH,
  parameter int SKID_DEPTH = fifo_pkg::DEF_SKID_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            rd_en,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic [$clog2(SKID_DEPTH+1)-1:0] occ
);

  localparam int PTR_W = $clog2(SKID_DEPTH);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage is reset too so the head word reads as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd_en) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// rtl/fifo_rd_stream_adapter.sv - FIFO read side to valid/ready stream; FIFO_RD_STATS_EN adds beat/stall counters
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SKID_DEPTH = DEF_SKID_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  fifo_rd_stream_adapter_if.master  bus,
  output logic                      busy,
  output logic                      err_underflow
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]               beat_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int LVL_W = OCC_W + 1;

  logic [OCC_W-1:0]      occ;
  logic                  inflight;
  logic                  pop;
  logic [LVL_W-1:0]      level_next;
  logic [LVL_W-1:0]      level_after;
  logic [DATA_WIDTH-1:0] head_data;
  occ_state_e            state;
  occ_state_e            state_next;

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (inflight),
    .wr_data (bus.fifo_data_out),
    .rd_en   (pop),
    .rd_data (head_data),
    .occ     (occ)
  );

  assign bus.m_valid = (occ != '0);
  assign bus.m_data  = head_data;
  assign pop         = bus.m_valid & bus.m_ready;

  // Reserve a slot for every beat already requested so the buffer can never overrun.
  assign level_next     = LVL_W'(occ) + LVL_W'(inflight) - LVL_W'(pop);
  assign bus.fifo_rd_en = en & ~bus.fifo_empty & (level_next < LVL_W'(SKID_DEPTH));
  assign level_after    = level_next + LVL_W'(bus.fifo_rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      err_underflow <= 1'b0;
      state         <= OCC_IDLE;
    end else begin
      inflight      <= bus.fifo_rd_en;
      err_underflow <= err_underflow | bus.fifo_underflow;
      state         <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    state_next = occ_state_of(32'(level_after), SKID_DEPTH);
  end

  // The state register tracks occ/inflight exactly, so busy comes straight from it.
  assign busy = (state != OCC_IDLE);

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      beat_cnt  <= beat_cnt + 32'(pop);
      stall_cnt <= stall_cnt + 32'(bus.m_valid & ~bus.m_ready);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb/tb_fifo_rd_stream_adapter.sv - scoreboard bench for fifo_rd_stream_adapter with a queue-based FIFO model
module tb_fifo_rd_stream_adapter;
  import fifo_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int SD = DEF_SKID_DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic busy;
  logic err_underflow;
`ifdef FIFO_RD_STATS_EN
  logic [31:0] beat_cnt;
  logic [31:0] stall_cnt;
`endif

  fifo_rd_stream_adapter_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rd_stream_adapter #(
    .DATA_WIDTH (DW),
    .SKID_DEPTH (SD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .bus           (bus),
    .busy          (busy),
    .err_underflow (err_underflow)
`ifdef FIFO_RD_STATS_EN
    ,
    .beat_cnt      (beat_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  fifo_data_t fifo_q[$];
  fifo_data_t exp_q[$];
  int rd_cyc[$];
  int beat_cyc[$];
  int cyc = 0;
  int rd_pulses = 0;
  int beats = 0;
  int stalls = 0;
  logic inj_uf = 1'b0;
  logic last_stall = 1'b0;
  logic [DW-1:0] last_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sync FIFO model: data returns the cycle after rd_en, empty and underflow are registered.
  always @(posedge clk or negedge rst_n) begin : fifo_model
    int n;
    if (!rst_n) begin
      bus.fifo_data_out  <= '0;
      bus.fifo_empty     <= 1'b1;
      bus.fifo_underflow <= 1'b0;
    end else begin
      n = fifo_q.size();
      if (bus.fifo_rd_en && n != 0) bus.fifo_data_out <= fifo_q.pop_front();
      bus.fifo_underflow <= inj_uf | (bus.fifo_rd_en & (n == 0));
      bus.fifo_empty     <= (fifo_q.size() == 0);
    end
  end

  always @(negedge clk) begin : monitor
    if (rst_n) begin
      if (bus.fifo_rd_en) begin
        rd_pulses++;
        rd_cyc.push_back(cyc);
        check("rd_en_needs_en", en, 1'b1);
        check("rd_en_needs_nonempty", bus.fifo_empty, 1'b0);
      end
      if (last_stall) begin
        check("m_valid_held", bus.m_valid, 1'b1);
        check("m_data_held", bus.m_data, last_data);
      end
      if (bus.m_valid && bus.m_ready) begin
        beats++;
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: actual=0x%0h required=no beat", bus.m_data);
        end else begin
          check("beat_data", bus.m_data, exp_q.pop_front());
        end
      end
      if (bus.m_valid && !bus.m_ready) stalls++;
      last_stall = bus.m_valid & ~bus.m_ready;
      last_data  = bus.m_data;
    end else begin
      last_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input fifo_data_t d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check("drain_scoreboard_empty", exp_q.size(), 0);
    check("drain_busy_low", busy, 1'b0);
  endtask

  initial begin
    int r0, b0, s0, beat_base, stall_base;
    bus.m_ready = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_fifo_rd_en", bus.fifo_rd_en, 1'b0);
    check("rst_m_valid", bus.m_valid, 1'b0);
    check("rst_m_data", bus.m_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_underflow, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1) four words at full rate, two-cycle latency
    r0 = rd_cyc.size();
    b0 = beat_cyc.size();
    for (int i = 1; i <= 4; i++) push(fifo_data_t'(i));
    bus.m_ready = 1'b1;
    en = 1'b1;
    wait_drain(50);
    check("t1_rd_pulses", rd_cyc.size() - r0, 4);
    check("t1_beats", beat_cyc.size() - b0, 4);
    if (rd_cyc.size() - r0 == 4 && beat_cyc.size() - b0 == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t1_rd_consecutive", rd_cyc[r0+i], rd_cyc[r0] + i);
        check("t1_beat_cycle", beat_cyc[b0+i], rd_cyc[r0] + 2 + i);
      end
    end

    // 2) stalled sink: only SD reads issued, head word held
    bus.m_ready = 1'b0;
    r0 = rd_pulses;
    for (int i = 0; i < 5; i++) push(fifo_data_t'(16'h0A00 + i));
    repeat (8) tick();
    check("t2_rd_pulses_stalled", rd_pulses - r0, SD);
    check("t2_m_valid", bus.m_valid, 1'b1);
    check("t2_m_data_first", bus.m_data, 16'h0A00);
    check("t2_busy", busy, 1'b1);
    bus.m_ready = 1'b1;
    wait_drain(50);
    check("t2_rd_pulses_total", rd_pulses - r0, 5);

    // 3) m_ready toggling 1010...
    b0 = beats;
    s0 = stalls;
    for (int i = 0; i < 10; i++) push(fifo_data_t'($urandom));
    for (int n = 0; n < 100 && (exp_q.size() != 0 || busy); n++) begin
      bus.m_ready = ~bus.m_ready;
      tick();
    end
    bus.m_ready = 1'b1;
    wait_drain(20);
    check("t3_beats", beats - b0, 10);
    check("t3_stalls_seen", (stalls - s0) > 0, 1'b1);
`ifdef FIFO_RD_STATS_EN
    check("t3_beat_cnt", beat_cnt, beats);
    check("t3_stall_cnt", stall_cnt, stalls);
`endif

    // 4) en dropped right after one read issues
    en = 1'b0;
    for (int i = 0; i < 4; i++) push(fifo_data_t'(16'h4400 + i));
    repeat (2) tick();
    r0 = rd_pulses;
    b0 = beats;
    en = 1'b1;
    tick();
    en = 1'b0;
    repeat (5) tick();
    check("t4_single_rd", rd_pulses - r0, 1);
    check("t4_inflight_beat_out", beats - b0, 1);
    check("t4_busy_after_drain", busy, 1'b0);
    check("t4_m_valid_after_drain", bus.m_valid, 1'b0);
    en = 1'b1;
    wait_drain(50);

    // 5) external underflow pulse sets sticky error
    inj_uf = 1'b1;
    tick();
    inj_uf = 1'b0;
    check("t5_err_before", err_underflow, 1'b0);
    tick();
    check("t5_err_set", err_underflow, 1'b1);
    repeat (3) tick();
    check("t5_err_sticky", err_underflow, 1'b1);

    // 6) async reset while the buffer is full
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(fifo_data_t'(16'h6600 + i));
    repeat (6) tick();
    check("t6_pre_valid", bus.m_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_m_valid", bus.m_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_rd_en", bus.fifo_rd_en, 1'b0);
    check("t6_rst_m_data", bus.m_data, '0);
    check("t6_rst_err", err_underflow, 1'b0);
    fifo_q.delete();
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    beat_base  = beats;
    stall_base = stalls;
    bus.m_ready = 1'b1;
    repeat (4) tick();
    check("t6_no_stale", beats - beat_base, 0);
    for (int i = 0; i < 3; i++) push(fifo_data_t'(16'h7700 + i));
    wait_drain(50);
    check("t6_fresh_beats", beats - beat_base, 3);

    // randomized traffic with random sink and enable
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < DEF_FIFO_DEPTH) push(fifo_data_t'($urandom));
      bus.m_ready = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 9) != 0);
      tick();
    end
    en = 1'b1;
    bus.m_ready = 1'b1;
    wait_drain(200);
`ifdef FIFO_RD_STATS_EN
    check("end_beat_cnt", beat_cnt, beats - beat_base);
    check("end_stall_cnt", stall_cnt, stalls - stall_base);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
